crypt_cmd_sched: RTL and testbench
==================================

CRYPT_CMD_SCHED -- requirements
Module: crypt_cmd_sched

Interface
REQ-001 SHALL have parameter RAW_W, default 60: raw (plaintext) data width.
REQ-002 SHALL have parameter ENC_W, default 78: encrypted data width; ENC_W > RAW_W.
REQ-003 SHALL have parameter DEPTH, default 4: response FIFO entries, power of two, >= 2.
REQ-004 SHALL have parameter ENC_LAT, default 3: encrypt latency in cycles, >= 1.
REQ-005 SHALL have parameter DEC_LAT, default 2: decrypt and password-gen latency in cycles, >= 1.
REQ-006 SHALL have port Clk, input, 1: single clock; all state changes on rising edge.
REQ-007 SHALL have port Rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port cmd_valid, input, 1: command present.
REQ-009 SHALL have port cmd_ready, output, 1: command accepted this cycle when both are high.
REQ-010 SHALL have port cmd_work, input, 2: 0 = encrypt, 1 = decrypt, 2 = password gen, 3 = illegal.
REQ-011 SHALL have port cmd_data, input, ENC_W: encrypt uses bits [RAW_W-1:0]; decrypt uses all bits; ignored for work 2.
REQ-012 SHALL have port eng_work, output, 2: work code driven to the engine.
REQ-013 SHALL have port eng_raw, output, RAW_W: engine raw input.
REQ-014 SHALL have port eng_enc, output, ENC_W: engine encrypted input.
REQ-015 SHALL have port eng_busy, output, 1: high while a job is in flight.
REQ-016 SHALL have port eng_out_enc, input, ENC_W: engine encrypt result.
REQ-017 SHALL have port eng_out_raw, input, RAW_W: engine decrypt / password result.
REQ-018 SHALL have port rsp_valid, output, 1: FIFO head valid.
REQ-019 SHALL have port rsp_ready, input, 1: consumer pops head when both are high.
REQ-020 SHALL have port rsp_data, output, ENC_W: result; raw results zero-extended.
REQ-021 SHALL have port rsp_work, output, 2: work code of the head entry.
REQ-022 SHALL have port rsp_count, output, $clog2(DEPTH+1): FIFO occupancy.
REQ-023 SHALL have port err_illegal, output, 1: one-cycle pulse on an accepted work 3.
REQ-024 SHALL have port err_sticky, output, 1: set by any illegal command; cleared only by reset.

Function
REQ-025 SHALL implement FSM states IDLE and RUN; only one job in flight.
REQ-026 SHALL drive cmd_ready = 1 only in IDLE with rsp_count < DEPTH.
REQ-027 SHALL, on an accepted work 0/1/2 at edge k, register eng_work/eng_raw/eng_enc at edge k, load latency counter with LAT-1 (ENC_LAT for 0, DEC_LAT otherwise), and enter RUN.
REQ-028 SHALL keep eng_* inputs stable during RUN; eng_busy = (state == RUN).
REQ-029 SHALL decrement the counter each RUN cycle; in the RUN cycle where the counter is 0, sample eng_out_enc (work 0) or eng_out_raw (work 1/2), push {work, data} at edge k+LAT, and return to IDLE.
REQ-030 SHALL make the pushed entry visible on rsp_* from edge k+LAT when the FIFO was empty; earliest next accept is edge k+LAT+1.
REQ-031 SHALL treat an accepted work 3 as not launched: pulse err_illegal, set err_sticky, no FIFO push, remain in IDLE.
REQ-032 SHALL pop on rsp_valid && rsp_ready; a simultaneous push and pop leaves rsp_count unchanged and preserves order.
REQ-033 SHALL wrap read/write pointers modulo DEPTH; a push never occurs when full (guaranteed by REQ-026).
REQ-034 SHALL keep rsp_data and rsp_work at zero when the FIFO is empty.
REQ-035 SHALL deliver responses strictly in command-acceptance order.

Reset
REQ-036 SHALL, while Rst_n = 0, asynchronously force IDLE, counter = 0, FIFO empty, and all outputs 0 (cmd_ready, eng_*, rsp_*, err_*).
REQ-037 SHALL discard an in-flight job on reset mid-RUN; no push occurs after release.
REQ-038 SHALL raise cmd_ready on the first rising edge after Rst_n deasserts.

Verification
REQ-039 SHALL verify: encrypt of cmd_data = 60'h0_0000_0000_00A5 with the engine model returning 78'h1234 -> rsp_data = 78'h1234, rsp_work = 0, rsp_valid 3 cycles after accept.
REQ-040 SHALL verify: decrypt with the engine returning 60'hABC -> rsp_data = 78'h0ABC zero-extended, latency 2, then password gen (work 2) queued behind it, delivered in order.
REQ-041 SHALL verify: rsp_ready = 0 and 4 commands issued -> rsp_count = 4 and cmd_ready = 0; one pop -> cmd_ready = 1 on the next cycle.
REQ-042 SHALL verify: work 3 -> err_illegal high exactly 1 cycle, err_sticky = 1, rsp_count unchanged, FSM stays in IDLE.
REQ-043 SHALL verify: Rst_n pulsed low mid-RUN with 2 entries queued -> outputs 0 immediately, no response appears afterwards.
REQ-044 SHALL verify: pop and completion push on the same edge with rsp_count = 2 -> rsp_count stays 2 and order is preserved.

Source files
------------

// File: rtl/crypt_cmd_sched.sv
// rtl/crypt_cmd_sched.sv - single-job crypto command scheduler with in-order response FIFO
//
// Purpose: accepts encrypt / decrypt / password-gen commands one at a time, drives
// a fixed-latency engine, and queues each result (tagged with its work code) in a
// DEPTH-entry response FIFO. Illegal work codes raise a pulse and a sticky flag.
//
// Ports:
//   Clk, Rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_work, cmd_data             0=enc, 1=dec, 2=password gen, 3=illegal; payload
//   eng_work/eng_raw/eng_enc       registered engine inputs, stable while eng_busy
//   eng_busy                       a job is in flight
//   eng_out_enc, eng_out_raw       engine results
//   rsp_valid/rsp_ready            response handshake (FIFO head)
//   rsp_data, rsp_work, rsp_count  head result (raw zero-extended), head work, occupancy
//   err_illegal, err_sticky        one-cycle illegal pulse, sticky illegal flag
module crypt_cmd_sched #(
  parameter int RAW_W   = 60,
  parameter int ENC_W   = 78,
  parameter int DEPTH   = 4,
  parameter int ENC_LAT = 3,
  parameter int DEC_LAT = 2
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_work,
  input  logic [ENC_W-1:0]           cmd_data,
  output logic [1:0]                 eng_work,
  output logic [RAW_W-1:0]           eng_raw,
  output logic [ENC_W-1:0]           eng_enc,
  output logic                       eng_busy,
  input  logic [ENC_W-1:0]           eng_out_enc,
  input  logic [RAW_W-1:0]           eng_out_raw,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ENC_W-1:0]           rsp_data,
  output logic [1:0]                 rsp_work,
  output logic [$clog2(DEPTH+1)-1:0] rsp_count,
  output logic                       err_illegal,
  output logic                       err_sticky
);

  localparam int LAT_MAX = (ENC_LAT > DEC_LAT) ? ENC_LAT : DEC_LAT;
  localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam int PW      = $clog2(DEPTH);
  localparam int NW      = $clog2(DEPTH+1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      lat_q, lat_d;
  logic [1:0]         work_q, work_d;
  logic [RAW_W-1:0]   raw_q, raw_d;
  logic [ENC_W-1:0]   enc_q, enc_d;
  logic               illegal_q, illegal_d;
  logic               sticky_q, sticky_d;
  // Holds cmd_ready low until the first edge after reset release.
  logic               rdy_en_q;

  logic [ENC_W+1:0]   mem [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]      count_q, count_d;

  logic               accept, push, pop;
  logic [ENC_W-1:0]   push_data;
  logic [ENC_W+1:0]   head;

  assign cmd_ready = rdy_en_q && (state_q == IDLE) && (count_q < NW'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state_q == RUN) && (lat_q == '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push_data = (work_q == 2'd0) ? eng_out_enc
                                      : {{(ENC_W-RAW_W){1'b0}}, eng_out_raw};

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    work_d    = work_q;
    raw_d     = raw_q;
    enc_d     = enc_q;
    illegal_d = 1'b0;
    sticky_d  = sticky_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_work == 2'd3) begin
            illegal_d = 1'b1;
            sticky_d  = 1'b1;
          end else begin
            work_d  = cmd_work;
            raw_d   = (cmd_work == 2'd0) ? cmd_data[RAW_W-1:0] : '0;
            enc_d   = (cmd_work == 2'd1) ? cmd_data : '0;
            lat_d   = (cmd_work == 2'd0) ? CW'(ENC_LAT-1) : CW'(DEC_LAT-1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (lat_q == '0) state_d = IDLE;
        else             lat_d   = lat_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      work_q    <= '0;
      raw_q     <= '0;
      enc_q     <= '0;
      illegal_q <= 1'b0;
      sticky_q  <= 1'b0;
      rdy_en_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      work_q    <= work_d;
      raw_q     <= raw_d;
      enc_q     <= enc_d;
      illegal_q <= illegal_d;
      sticky_q  <= sticky_d;
      rdy_en_q  <= 1'b1;
      count_q   <= count_d;
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: every read is gated by a non-zero occupancy.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_q] <= {work_q, push_data};
  end

  assign head        = mem[rd_ptr_q];
  assign rsp_valid   = (count_q != '0);
  assign rsp_data    = rsp_valid ? head[ENC_W-1:0] : '0;
  assign rsp_work    = rsp_valid ? head[ENC_W+1:ENC_W] : 2'd0;
  assign rsp_count   = count_q;
  assign eng_work    = work_q;
  assign eng_raw     = raw_q;
  assign eng_enc     = enc_q;
  assign eng_busy    = (state_q == RUN);
  assign err_illegal = illegal_q;
  assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_crypt_cmd_sched.sv
// tb/tb_crypt_cmd_sched.sv - directed self-checking bench for crypt_cmd_sched
module tb_crypt_cmd_sched;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_work;
  logic [77:0] cmd_data;
  logic [1:0]  eng_work;
  logic [59:0] eng_raw;
  logic [77:0] eng_enc;
  logic        eng_busy;
  logic [77:0] eng_out_enc;
  logic [59:0] eng_out_raw;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [77:0] rsp_data;
  logic [1:0]  rsp_work;
  logic [2:0]  rsp_count;
  logic        err_illegal;
  logic        err_sticky;

  logic        enc_force;
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          ok;

  always #5 Clk = ~Clk;

  // Engine model: fixed encrypt answer when forced, otherwise a tag derived from the input.
  assign eng_out_enc = enc_force ? 78'h1234 : {18'h3, eng_raw};
  assign eng_out_raw = (eng_work == 2'd1) ? 60'hABC : 60'h5A5;

  crypt_cmd_sched dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_work(cmd_work), .cmd_data(cmd_data),
    .eng_work(eng_work), .eng_raw(eng_raw), .eng_enc(eng_enc), .eng_busy(eng_busy),
    .eng_out_enc(eng_out_enc), .eng_out_raw(eng_out_raw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_work(rsp_work),
    .rsp_count(rsp_count), .err_illegal(err_illegal), .err_sticky(err_sticky)
  );

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Presents a command, waits (bounded) for acceptance, returns just after the accept edge.
  task automatic send(input logic [1:0] w, input logic [77:0] d, output bit accepted);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_work  = w;
    cmd_data  = d;
    while (!cmd_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    accepted = cmd_ready;
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; cmd_valid = 1'b0; cmd_work = 2'd0; cmd_data = '0;
    rsp_ready = 1'b0; enc_force = 1'b1;

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst_cmd_ready", 80'(cmd_ready), 80'(0));
    check("rst_rsp_valid", 80'(rsp_valid), 80'(0));
    check("rst_rsp_count", 80'(rsp_count), 80'(0));
    check("rst_eng_busy",  80'(eng_busy),  80'(0));
    check("rst_sticky",    80'(err_sticky), 80'(0));
    Rst_n = 1'b1;
    #1 check("rel_ready_before_edge", 80'(cmd_ready), 80'(0));
    @(negedge Clk);
    check("rel_ready_after_edge", 80'(cmd_ready), 80'(1));

    // Encrypt, latency 3
    send(2'd0, 78'hA5, ok);
    check("enc_accept", 80'(ok), 80'(1));
    @(negedge Clk);
    check("enc_busy",     80'(eng_busy), 80'(1));
    check("enc_eng_raw",  80'(eng_raw),  80'h0A5);
    check("enc_eng_work", 80'(eng_work), 80'(0));
    check("enc_valid_c0", 80'(rsp_valid), 80'(0));
    repeat (2) begin
      @(negedge Clk);
      check("enc_valid_early", 80'(rsp_valid), 80'(0));
    end
    @(negedge Clk);
    check("enc_valid", 80'(rsp_valid), 80'(1));
    check("enc_data",  80'(rsp_data),  80'h1234);
    check("enc_work",  80'(rsp_work),  80'(0));
    check("enc_count", 80'(rsp_count), 80'(1));
    check("enc_idle",  80'(eng_busy),  80'(0));
    rsp_ready = 1'b1;
    @(negedge Clk);
    rsp_ready = 1'b0;
    check("empty_valid", 80'(rsp_valid), 80'(0));
    check("empty_data",  80'(rsp_data),  80'(0));
    check("empty_work",  80'(rsp_work),  80'(0));

    // Decrypt, latency 2, then password gen behind it
    send(2'd1, 78'h2_0000_0000_0000_0FED, ok);
    check("dec_accept", 80'(ok), 80'(1));
    @(negedge Clk);
    check("dec_eng_enc", 80'(eng_enc), 80'h2_0000_0000_0000_0FED);
    check("dec_valid_c0", 80'(rsp_valid), 80'(0));
    @(negedge Clk);
    check("dec_valid_c1", 80'(rsp_valid), 80'(0));
    @(negedge Clk);
    check("dec_valid", 80'(rsp_valid), 80'(1));
    check("dec_data",  80'(rsp_data),  80'h0ABC);
    check("dec_work",  80'(rsp_work),  80'(1));
    send(2'd2, 78'h0, ok);
    check("pw_accept", 80'(ok), 80'(1));
    repeat (3) @(negedge Clk);
    check("pw_count",     80'(rsp_count), 80'(2));
    check("pw_head_data", 80'(rsp_data),  80'h0ABC);
    rsp_ready = 1'b1;
    @(negedge Clk);
    check("pw_data",  80'(rsp_data),  80'h05A5);
    check("pw_work",  80'(rsp_work),  80'(2));
    check("pw_count1", 80'(rsp_count), 80'(1));
    @(negedge Clk);
    rsp_ready = 1'b0;
    check("pw_drained", 80'(rsp_count), 80'(0));

    // Fill the FIFO with the consumer stalled
    enc_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(2'd0, 78'(16 + i), ok);
      check("full_accept", 80'(ok), 80'(1));
    end
    repeat (4) @(negedge Clk);
    check("full_count", 80'(rsp_count), 80'(4));
    check("full_ready", 80'(cmd_ready), 80'(0));
    rsp_ready = 1'b1;
    @(negedge Clk);
    check("full_pop_count", 80'(rsp_count), 80'(3));
    check("full_pop_ready", 80'(cmd_ready), 80'(1));
    for (int i = 1; i < 4; i++) begin
      logic [77:0] e;
      e = {18'h3, 60'(16 + i)};
      check("full_order", 80'(rsp_data), 80'(e));
      @(negedge Clk);
    end
    rsp_ready = 1'b0;
    check("full_drained", 80'(rsp_count), 80'(0));

    // Illegal work code
    send(2'd3, 78'h0, ok);
    check("ill_accept", 80'(ok), 80'(1));
    @(negedge Clk);
    check("ill_pulse",  80'(err_illegal), 80'(1));
    check("ill_sticky", 80'(err_sticky),  80'(1));
    check("ill_count",  80'(rsp_count),   80'(0));
    check("ill_idle",   80'(eng_busy),    80'(0));
    check("ill_ready",  80'(cmd_ready),   80'(1));
    @(negedge Clk);
    check("ill_pulse_end", 80'(err_illegal), 80'(0));
    check("ill_sticky2",   80'(err_sticky),  80'(1));

    // Pop and completion push on the same edge at count 2
    send(2'd0, 78'h21, ok);
    send(2'd0, 78'h22, ok);
    send(2'd0, 78'h23, ok);
    check("same_accept", 80'(ok), 80'(1));
    repeat (3) @(negedge Clk);
    check("same_pre_count", 80'(rsp_count), 80'(2));
    check("same_pre_busy",  80'(eng_busy),  80'(1));
    rsp_ready = 1'b1;
    @(negedge Clk);
    rsp_ready = 1'b0;
    check("same_count", 80'(rsp_count), 80'(2));
    check("same_head",  80'(rsp_data),  80'({18'h3, 60'h22}));
    rsp_ready = 1'b1;
    @(negedge Clk);
    check("same_tail", 80'(rsp_data), 80'({18'h3, 60'h23}));
    @(negedge Clk);
    rsp_ready = 1'b0;
    check("same_drained", 80'(rsp_count), 80'(0));

    // Reset mid-RUN with two entries queued
    send(2'd0, 78'h31, ok);
    send(2'd0, 78'h32, ok);
    send(2'd0, 78'h33, ok);
    @(negedge Clk);
    check("mid_busy",  80'(eng_busy),  80'(1));
    check("mid_count", 80'(rsp_count), 80'(2));
    #2 Rst_n = 1'b0;
    #1;
    check("mid_rst_ready",  80'(cmd_ready),  80'(0));
    check("mid_rst_valid",  80'(rsp_valid),  80'(0));
    check("mid_rst_count",  80'(rsp_count),  80'(0));
    check("mid_rst_busy",   80'(eng_busy),   80'(0));
    check("mid_rst_raw",    80'(eng_raw),    80'(0));
    check("mid_rst_data",   80'(rsp_data),   80'(0));
    check("mid_rst_sticky", 80'(err_sticky), 80'(0));
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (6) @(negedge Clk);
    check("post_rst_count", 80'(rsp_count), 80'(0));
    check("post_rst_valid", 80'(rsp_valid), 80'(0));
    check("post_rst_ready", 80'(cmd_ready), 80'(1));
    check("post_rst_busy",  80'(eng_busy),  80'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog");
  end

endmodule
